// File: rtl/maze_port_arbiter.sv
// Two-client round-robin arbiter in front of a 1-bit-per-cell maze memory.
// Write: ack one cycle after selection. Read: strobe after one, ack+rdata after two.
// Clients hold req until ack; at most one transaction is in flight.
module maze_port_arbiter #(
    parameter int N_CLI = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       c0_req,
    input  logic       c1_req,
    input  logic       c0_we,
    input  logic       c1_we,
    input  logic [5:0] c0_row,
    input  logic [5:0] c0_col,
    input  logic [5:0] c1_row,
    input  logic [5:0] c1_col,
    input  logic       c0_done,
    input  logic       c1_done,
    output logic       c0_ack,
    output logic       c1_ack,
    output logic       c0_rdata,
    output logic       c1_rdata,
    output logic [5:0] row,
    output logic [5:0] col,
    output logic       maze_oe,
    output logic       maze_we,
    input  logic       maze_in,
    output logic       busy
);
    localparam int OW = $clog2(N_CLI);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] RDATA = 2'd2;

    logic [1:0]    state;
    logic [OW-1:0] owner;
    logic [OW-1:0] last;
    logic [OW-1:0] win;
    logic          we_q;
    logic [5:0]    row_q;
    logic [5:0]    col_q;
    logic [1:0]    rd_q;
    logic          elig0;
    logic          elig1;
    logic          in_issue;
    logic          in_rdata;
    logic          finish;

    assign elig0 = c0_req & ~c0_done;
    assign elig1 = c1_req & ~c1_done;
    // On a tie the client not served last wins; otherwise the lone eligible one.
    assign win   = (elig0 & elig1) ? ~last : OW'(elig1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            owner <= '0;
            last  <= OW'(1);
            we_q  <= 1'b0;
            row_q <= '0;
            col_q <= '0;
            rd_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (elig0 | elig1) begin
                        owner <= win;
                        last  <= win;
                        we_q  <= (win == '0) ? c0_we  : c1_we;
                        row_q <= (win == '0) ? c0_row : c1_row;
                        col_q <= (win == '0) ? c0_col : c1_col;
                        state <= ISSUE;
                    end
                end
                ISSUE:   state <= we_q ? IDLE : RDATA;
                RDATA: begin
                    rd_q[owner] <= maze_in;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Strobes, acks and the live rdata path are squashed while rst is high so
    // a transaction interrupted by reset produces nothing.
    assign in_issue = (state == ISSUE) & ~rst;
    assign in_rdata = (state == RDATA) & ~rst;
    assign finish   = (in_issue & we_q) | in_rdata;

    assign maze_we  = in_issue & we_q;
    assign maze_oe  = in_issue & ~we_q;
    assign c0_ack   = finish & (owner == '0);
    assign c1_ack   = finish & (owner != '0);
    assign c0_rdata = rst ? 1'b0 : ((in_rdata & (owner == '0)) ? maze_in : rd_q[0]);
    assign c1_rdata = rst ? 1'b0 : ((in_rdata & (owner != '0)) ? maze_in : rd_q[1]);
    assign row      = row_q;
    assign col      = col_q;
    assign busy     = (state != IDLE);
endmodule

// File: tb/tb_maze_port_arbiter.sv
// Bench for maze_port_arbiter: vector table, directed corner sequences, and a
// randomized run against a transaction-level reference model.
module tb_maze_port_arbiter;
    logic       clk = 1'b0;
    logic       rst;
    logic       c0_req, c1_req, c0_we, c1_we, c0_done, c1_done;
    logic [5:0] c0_row, c0_col, c1_row, c1_col;
    logic       c0_ack, c1_ack, c0_rdata, c1_rdata, maze_oe, maze_we, busy;
    logic [5:0] row, col;
    logic       maze_in;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    maze_port_arbiter #(.N_CLI(2)) dut (
        .clk(clk), .rst(rst),
        .c0_req(c0_req), .c1_req(c1_req), .c0_we(c0_we), .c1_we(c1_we),
        .c0_row(c0_row), .c0_col(c0_col), .c1_row(c1_row), .c1_col(c1_col),
        .c0_done(c0_done), .c1_done(c1_done),
        .c0_ack(c0_ack), .c1_ack(c1_ack), .c0_rdata(c0_rdata), .c1_rdata(c1_rdata),
        .row(row), .col(col), .maze_oe(maze_oe), .maze_we(maze_we),
        .maze_in(maze_in), .busy(busy)
    );

    // Synchronous maze memory: a write marks the cell, read data follows oe by one cycle.
    logic       mem [4096];
    logic       ref_mem [4096];
    logic       mem_q = 1'b0;
    logic       tab_mode = 1'b1;
    logic       tab_min = 1'b0;
    assign maze_in = tab_mode ? tab_min : mem_q;

    always @(posedge clk) begin
        if (maze_we) mem[{row, col}] <= 1'b1;
        if (maze_oe) mem_q <= mem[{row, col}];
    end

    typedef struct {
        logic       q0, w0, d0;
        logic [5:0] r0, k0;
        logic       q1, w1, d1;
        logic [5:0] r1, k1;
        logic       m;
        logic [18:0] e;
    } tv_t;

    function automatic logic [18:0] ev(input logic a0, a1, d0, d1, oe, we, b,
                                       input logic [5:0] r, c);
        return {a0, a1, d0, d1, oe, we, b, r, c};
    endfunction

    function automatic tv_t mkv(input logic q0, w0, d0, input logic [5:0] r0, k0,
                                input logic q1, w1, d1, input logic [5:0] r1, k1,
                                input logic m, input logic [18:0] e);
        tv_t t;
        t.q0 = q0; t.w0 = w0; t.d0 = d0; t.r0 = r0; t.k0 = k0;
        t.q1 = q1; t.w1 = w1; t.d1 = d1; t.r1 = r1; t.k1 = k1;
        t.m = m; t.e = e;
        return t;
    endfunction

    function automatic logic [18:0] outv();
        return {c0_ack, c1_ack, c0_rdata, c1_rdata, maze_oe, maze_we, busy, row, col};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    task automatic clr_in();
        c0_req = 0; c1_req = 0; c0_we = 0; c1_we = 0; c0_done = 0; c1_done = 0;
        c0_row = 0; c0_col = 0; c1_row = 0; c1_col = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clr_in();
        next_cycle();
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        chk("reset_state", 32'(outv()), 32'd0);
        next_cycle();
    endtask

    // Reference model state (transaction level: k = cycles since grant, 0 = none).
    int         k, m_own, m_last;
    logic       m_we;
    logic [5:0] m_row, m_col;
    logic [1:0] m_rd;
    logic       creq [2], cwe [2], cdone [2];
    logic [5:0] crow [2], ccol [2];

    task automatic new_req(input int i);
        creq[i] = 1'b1;
        cwe[i]  = 1'($urandom_range(1));
        crow[i] = 6'($urandom_range(63));
        ccol[i] = 6'($urandom_range(63));
    endtask

    initial begin
        tv_t tbl [13];
        int  order [$];
        int  n0, n1, ovl;
        logic ack_now, el0, el1;
        logic [1:0] e_ack, e_rd;

        for (int a = 0; a < 4096; a++) begin
            mem[a]     = 1'($urandom_range(1));
            ref_mem[a] = mem[a];
        end

        tbl[0]  = mkv(1,0,0,5,7, 0,0,0,0,0,  0, ev(0,0,0,0,0,0,0,0,0));
        tbl[1]  = mkv(1,0,0,5,7, 0,0,0,0,0,  0, ev(0,0,0,0,1,0,1,5,7));
        tbl[2]  = mkv(1,0,0,5,7, 0,0,0,0,0,  1, ev(1,0,1,0,0,0,1,5,7));
        tbl[3]  = mkv(0,0,0,0,0, 0,0,0,0,0,  0, ev(0,0,1,0,0,0,0,5,7));
        tbl[4]  = mkv(0,0,0,0,0, 1,1,0,0,63, 0, ev(0,0,1,0,0,0,0,5,7));
        tbl[5]  = mkv(0,0,0,0,0, 1,1,0,0,63, 0, ev(0,1,1,0,0,1,1,0,63));
        tbl[6]  = mkv(0,0,0,0,0, 0,0,0,0,0,  0, ev(0,0,1,0,0,0,0,0,63));
        tbl[7]  = mkv(0,0,0,0,0, 1,0,0,63,0, 0, ev(0,0,1,0,0,0,0,0,63));
        tbl[8]  = mkv(0,0,0,0,0, 1,0,0,63,0, 0, ev(0,0,1,0,1,0,1,63,0));
        tbl[9]  = mkv(0,0,0,0,0, 1,0,0,63,0, 1, ev(0,1,1,1,0,0,1,63,0));
        tbl[10] = mkv(0,0,0,0,0, 0,0,0,0,0,  0, ev(0,0,1,1,0,0,0,63,0));
        tbl[11] = mkv(1,0,1,1,1, 0,0,0,0,0,  0, ev(0,0,1,1,0,0,0,63,0));
        tbl[12] = mkv(1,0,1,1,1, 0,0,0,0,0,  0, ev(0,0,1,1,0,0,0,63,0));

        clr_in();
        do_reset();

        for (int i = 0; i < 13; i++) begin
            c0_req = tbl[i].q0; c0_we = tbl[i].w0; c0_done = tbl[i].d0;
            c0_row = tbl[i].r0; c0_col = tbl[i].k0;
            c1_req = tbl[i].q1; c1_we = tbl[i].w1; c1_done = tbl[i].d1;
            c1_row = tbl[i].r1; c1_col = tbl[i].k1;
            tab_min = tbl[i].m;
            @(negedge clk);
            chk($sformatf("vec%0d", i), 32'(outv()), 32'(tbl[i].e));
            next_cycle();
        end

        // Tie after reset and fairness: both clients read continuously.
        do_reset();
        c0_req = 1; c0_row = 6'd3; c0_col = 6'd4;
        c1_req = 1; c1_row = 6'd9; c1_col = 6'd8;
        ovl = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (c0_ack && c1_ack) ovl++;
            if (c0_ack) order.push_back(0);
            if (c1_ack) order.push_back(1);
            next_cycle();
        end
        chk("fair_count", 32'(order.size()), 32'd4);
        chk("fair_overlap", 32'(ovl), 32'd0);
        for (int i = 0; i < 4; i++)
            chk($sformatf("fair_order%0d", i), (i < order.size()) ? 32'(order[i]) : 32'hFFFF, 32'(i % 2));

        // Done mask: c0 has exited, only c1 is served, one write per 2 cycles.
        do_reset();
        c0_req = 1; c0_we = 1; c0_done = 1;
        c1_req = 1; c1_we = 1; c1_row = 6'd2; c1_col = 6'd2;
        n0 = 0; n1 = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n0 += int'(c0_ack);
            n1 += int'(c1_ack);
            next_cycle();
        end
        chk("done_c1_acks", 32'(n1), 32'd5);
        chk("done_c0_acks", 32'(n0), 32'd0);

        // Reset during RDATA drops the read and restores the tie pointer.
        do_reset();
        c0_req = 1; c0_row = 6'd10; c0_col = 6'd11;
        next_cycle();
        next_cycle();
        rst = 1'b1;
        @(negedge clk);
        chk("rstmid_noack", {30'd0, c0_ack, c1_ack}, 32'd0);
        next_cycle();
        rst = 1'b0;
        clr_in();
        @(negedge clk);
        chk("rstmid_outputs", 32'(outv()), 32'd0);
        next_cycle();
        c0_req = 1; c0_we = 1; c1_req = 1; c1_we = 1;
        next_cycle();
        @(negedge clk);
        chk("rstmid_tie", {30'd0, c0_ack, c1_ack}, 32'b10);
        next_cycle();

        // Back-to-back writes by c0.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            c0_req = 1; c0_we = 1;
            c0_row = 6'(i * 9); c0_col = 6'(63 - i * 5);
            @(negedge clk);
            chk($sformatf("b2b_idle%0d", i), {31'd0, maze_we}, 32'd0);
            next_cycle();
            @(negedge clk);
            chk($sformatf("b2b_wr%0d", i), {18'd0, maze_we, c0_ack, row, col},
                {18'd0, 1'b1, 1'b1, 6'(i * 9), 6'(63 - i * 5)});
            next_cycle();
        end

        // Randomized traffic against the reference model.
        for (int a = 0; a < 4096; a++) ref_mem[a] = mem[a];
        tab_mode = 1'b0;
        do_reset();
        k = 0; m_own = 0; m_last = 1; m_we = 0; m_row = 0; m_col = 0; m_rd = 0;
        for (int i = 0; i < 2; i++) begin
            creq[i] = 0; cwe[i] = 0; cdone[i] = 0; crow[i] = 0; ccol[i] = 0;
        end
        for (int cyc = 0; cyc < 3000; cyc++) begin
            c0_req = creq[0]; c0_we = cwe[0]; c0_done = cdone[0]; c0_row = crow[0]; c0_col = ccol[0];
            c1_req = creq[1]; c1_we = cwe[1]; c1_done = cdone[1]; c1_row = crow[1]; c1_col = ccol[1];
            @(negedge clk);
            ack_now = (k == 1 && m_we) || (k == 2 && !m_we);
            e_ack = 2'b00;
            e_rd  = m_rd;
            if (ack_now) begin
                e_ack[m_own] = 1'b1;
                if (!m_we) e_rd[m_own] = ref_mem[{m_row, m_col}];
            end
            chk($sformatf("rand%0d", cyc), 32'(outv()),
                32'(ev(e_ack[0], e_ack[1], e_rd[0], e_rd[1], k == 1 && !m_we,
                       k == 1 && m_we, k != 0, m_row, m_col)));
            if (ack_now) begin
                m_rd = e_rd;
                if (m_we) ref_mem[{m_row, m_col}] = 1'b1;
                k = 0;
            end else if (k != 0) begin
                k++;
            end else begin
                el0 = creq[0] && !cdone[0];
                el1 = creq[1] && !cdone[1];
                if (el0 || el1) begin
                    m_own  = (el0 && el1) ? 1 - m_last : (el1 ? 1 : 0);
                    m_last = m_own;
                    m_we   = cwe[m_own];
                    m_row  = crow[m_own];
                    m_col  = ccol[m_own];
                    k      = 1;
                end
            end
            for (int i = 0; i < 2; i++) begin
                if (creq[i] && e_ack[i]) begin
                    if ($urandom_range(1) == 1) new_req(i);
                    else creq[i] = 1'b0;
                end else if (!creq[i] && $urandom_range(2) == 0) begin
                    new_req(i);
                end
                if ($urandom_range(7) == 0) cdone[i] = ~cdone[i];
            end
            next_cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/maze_port_arbiter.md
MAZE_PORT_ARBITER -- requirements
Module: maze_port_arbiter

Interface
REQ-001 SHALL have parameter N_CLI, default 2, the number of solver clients (fixed at 2 for this revision).
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-004 SHALL have ports c0_req and c1_req, input, 1 each; the client requests one maze access and holds the request until its ack.
REQ-005 SHALL have ports c0_we and c1_we, input, 1 each; 1 = write (mark cell), 0 = read; stable while req is high.
REQ-006 SHALL have ports c0_row, c0_col, c1_row and c1_col, input, 6 each; the target cell, stable while req is high.
REQ-007 SHALL have ports c0_done and c1_done, input, 1 each; high = client has exited the maze, and its req is ignored.
REQ-008 SHALL have ports c0_ack and c1_ack, output, 1 each; a one-cycle completion pulse.
REQ-009 SHALL have ports c0_rdata and c1_rdata, output, 1 each; the read result (1 = wall), valid in the ack cycle of a read.
REQ-010 SHALL have ports row and col, output, 6 each; the cell select to the maze memory.
REQ-011 SHALL have ports maze_oe and maze_we, output, 1 each; the memory read and write strobes.
REQ-012 SHALL have port maze_in, input, 1; memory read data, valid the cycle after maze_oe.
REQ-013 SHALL have port busy, output, 1; high in any state other than IDLE.

Function
REQ-014 SHALL implement the FSM states IDLE, ISSUE and RDATA.
REQ-015 SHALL, in IDLE, treat a client as eligible when reqX=1 and doneX=0; with no eligible client it SHALL stay in IDLE.
REQ-016 SHALL, in IDLE with at least one eligible client, select one, latch its index, row, col and we into internal registers, and go to ISSUE next cycle.
REQ-017 SHALL arbitrate round-robin: with both clients eligible, it selects the client not served last; with one eligible, it selects that client.
REQ-018 SHALL set the last-served pointer to the winner at selection.
REQ-019 SHALL, in ISSUE, drive row and col from the latched values and assert exactly one of maze_we (write) or maze_oe (read) for exactly one cycle.
REQ-020 SHALL, in ISSUE for a write, pulse ack of the owner in that same cycle and return to IDLE.
REQ-021 SHALL, in ISSUE for a read, go to RDATA.
REQ-022 SHALL, in RDATA, present maze_in on the owner's rdata, pulse the owner's ack, and return to IDLE.
REQ-023 SHALL meet these latencies, measured from the IDLE cycle N in which req is sampled: write ack in cycle N+1; read strobe in cycle N+1; read ack and rdata in cycle N+2.
REQ-024 SHALL sustain throughput of one write per 2 cycles and one read per 3 cycles.
REQ-025 SHALL never assert maze_oe and maze_we in the same cycle, and SHALL never assert either outside ISSUE.
REQ-026 SHALL never assert ack to more than one client in a cycle, nor to a non-owner.
REQ-027 SHALL hold rdata at its last value outside the ack cycle.
REQ-028 SHALL hold row and col at their last driven values in IDLE and RDATA.
REQ-029 SHALL not abort or alter an in-flight transaction when reqX or doneX changes after selection; the ack is still delivered.
REQ-030 SHALL accept back-to-back traffic: a client that re-asserts req in the cycle after ack is eligible in that IDLE cycle.
REQ-031 SHALL treat row and col as 6-bit opaque values with no range checking; 0 and 63 are passed through unchanged.

Reset
REQ-032 SHALL, while rst=1 at a clock edge, go to IDLE.
REQ-033 SHALL reset the outputs as follows: row=0, col=0, maze_oe=0, maze_we=0, c0_ack=0, c1_ack=0, c0_rdata=0, c1_rdata=0, busy=0.
REQ-034 SHALL, on reset, point the last-served pointer at client 1 so that client 0 wins the first tie.
REQ-035 SHALL, on reset during ISSUE or RDATA, drop the in-flight transaction: no ack and no further strobe; the client must re-request.
REQ-036 SHALL ignore all inputs during the reset cycle.

Verification
REQ-037 SHALL be verified for a single read: c0 reads (5,7), memory returns 1 -> maze_oe=1 with row=5, col=7 at N+1; c0_ack=1 and c0_rdata=1 at N+2; busy low at N+3.
REQ-038 SHALL be verified for a single write: c1 writes (0,63) -> maze_we=1 with row=0, col=63 and c1_ack=1 at N+1; maze_oe stays 0 throughout.
REQ-039 SHALL be verified for a tie after reset and fairness: both clients request reads continuously -> grant order c0, c1, c0, c1; no client starves, and acks never overlap.
REQ-040 SHALL be verified for the done mask: c0_done=1 with c0_req=1 and c1_req=1 -> only c1 is served repeatedly; c0_ack never asserts.
REQ-041 SHALL be verified for reset mid-read: rst=1 during RDATA -> no ack; next cycle all outputs at reset values; c0 wins the next tie.
REQ-042 SHALL be verified for back-to-back writes by c0 (c1 idle) -> maze_we pulses every 2 cycles with correct coordinates each time.
